// File: rtl/lcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// lcd_seq_pkg
// Shared definitions for the HD44780-style LCD bus sequencer:
//   - sequencer FSM state encoding
//   - Avalon-MM register addresses and STATUS bit positions
//   - instruction codes that need the long execution wait
//   - helper that classifies a transfer as long or normal
// -----------------------------------------------------------------------------
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } state_e;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int BUSY_BIT = 0;
    localparam int OVF_BIT  = 1;
    localparam int FULL_BIT = 2;

    // Clear display and the two return-home encodings run far longer on the panel
    localparam logic [7:0] LONG_CLEAR    = 8'h01;
    localparam logic [7:0] LONG_HOME     = 8'h02;
    localparam logic [7:0] LONG_HOME_ALT = 8'h03;

    function automatic logic is_long_instr(input logic rs, input logic [7:0] code);
        return (rs == 1'b0) &&
               ((code == LONG_CLEAR) || (code == LONG_HOME) || (code == LONG_HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_seq_fifo.sv
// -----------------------------------------------------------------------------
// lcd_seq_fifo
// Small synchronous first-word-fall-through FIFO holding pending {rs, byte}
// transfers for the LCD sequencer. A push while full is accepted only when a
// pop happens in the same cycle (the pop frees the slot first).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, wr_data     enqueue request and its payload
//   pop               dequeue request (ignored when empty)
//   rd_data           head entry, valid while empty == 0
//   full, empty       occupancy flags
//   count             number of stored entries
// -----------------------------------------------------------------------------
module lcd_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign do_pop_s  = pop & (count_r != {(AW+1){1'b0}});
    assign do_push_s = push & ((count_r != (AW+1)'(DEPTH)) | do_pop_s);

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign count   = count_r;

    // Storage array and pointers; pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {(AW+1){1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_bus_sequencer
// Avalon-MM slave that drives HD44780-style 8-bit LCD write cycles with
// hardware-timed setup, enable pulse, hold and execution wait.
// Optional command queue enabled by defining LCD_SEQ_FIFO_EN.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address                 0 CMD, 1 DATA, 2 STATUS, 3 reserved
//   chipselect, write_n     write strobe = chipselect & ~write_n
//   writedata               byte written
//   readdata                combinational read (STATUS: bit0 busy, bit1 ovf, bit2 full)
//   lcd_e, lcd_rs, lcd_rw   LCD control pins (lcd_rw fixed at 0)
//   lcd_data                LCD data bus
// -----------------------------------------------------------------------------
module lcd_bus_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 82000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       chipselect,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int CNT_W = $clog2(T_EXEC_LONG + 1);

    if ((T_SETUP < 1) || (T_PULSE < 1) || (T_HOLD < 1) || (T_EXEC < 1) ||
        (T_EXEC_LONG < T_EXEC) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
        $error("lcd_bus_sequencer: illegal timing or FIFO_DEPTH parameter");
    end

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             long_sel_r;
    logic             lcd_e_r;
    logic             lcd_rs_r;
    logic [7:0]       lcd_data_r;
    logic             ovf_r;

    logic             wr_s;
    logic             xfer_wr_s;
    logic             wr_rs_s;
    logic             ovf_clr_s;
    logic             start_s;
    logic             start_rs_s;
    logic [7:0]       start_byte_s;
    logic             busy_s;
    logic             full_s;
    logic             ovf_set_s;
    logic [7:0]       status_s;

    assign wr_s      = chipselect & ~write_n;
    assign xfer_wr_s = wr_s & ((address == ADDR_CMD) | (address == ADDR_DATA));
    assign wr_rs_s   = (address == ADDR_DATA);
    assign ovf_clr_s = wr_s & (address == ADDR_STATUS) & writedata[OVF_BIT];

`ifdef LCD_SEQ_FIFO_EN
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [8:0]                  fifo_rd_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                        push_s;

    // Every transfer goes through the queue; the FSM only ever starts from its head
    assign start_s   = (state_r == ST_IDLE) & ~fifo_empty_s;
    assign push_s    = xfer_wr_s & (~fifo_full_s | start_s);
    assign ovf_set_s = xfer_wr_s & fifo_full_s & ~start_s;
    assign {start_rs_s, start_byte_s} = fifo_rd_s;
    assign busy_s    = (state_r != ST_IDLE) | (fifo_count_s != {($clog2(FIFO_DEPTH)+1){1'b0}});
    assign full_s    = fifo_full_s;

    lcd_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .wr_data ({wr_rs_s, writedata}),
        .pop     (start_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );
`else
    // Single transfer in flight; anything arriving while active (including the
    // final EXEC cycle) is dropped
    assign start_s      = (state_r == ST_IDLE) & xfer_wr_s;
    assign start_rs_s   = wr_rs_s;
    assign start_byte_s = writedata;
    assign busy_s       = (state_r != ST_IDLE);
    assign full_s       = busy_s;
    assign ovf_set_s    = xfer_wr_s & busy_s;
`endif

    // FSM state and phase down-counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: counter holds remaining cycles minus one of the current phase
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_SETUP;
                    cnt_s   = CNT_W'(T_SETUP - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_PULSE;
                    cnt_s   = CNT_W'(T_PULSE - 1);
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_HOLD;
                    cnt_s   = CNT_W'(T_HOLD - 1);
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_EXEC;
                    cnt_s   = long_sel_r ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered enable: high exactly while the FSM sits in PULSE, no decode glitches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_e_r <= 1'b0;
        end else begin
            lcd_e_r <= (state_s == ST_PULSE);
        end
    end

    // Bus pins latched on transfer start and held after completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_rs_r   <= 1'b0;
            lcd_data_r <= 8'h00;
            long_sel_r <= 1'b0;
        end else if (start_s) begin
            lcd_rs_r   <= start_rs_s;
            lcd_data_r <= start_byte_s;
            long_sel_r <= is_long_instr(start_rs_s, start_byte_s);
        end else begin
            lcd_rs_r   <= lcd_rs_r;
            lcd_data_r <= lcd_data_r;
            long_sel_r <= long_sel_r;
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Read mux: only STATUS returns data
    always_comb begin
        status_s           = 8'h00;
        status_s[BUSY_BIT] = busy_s;
        status_s[OVF_BIT]  = ovf_r;
        status_s[FULL_BIT] = full_s;
        case (address)
            ADDR_STATUS: readdata = status_s;
            default:     readdata = 8'h00;
        endcase
    end

    assign lcd_e    = lcd_e_r;
    assign lcd_rs   = lcd_rs_r;
    assign lcd_rw   = 1'b0;
    assign lcd_data = lcd_data_r;

endmodule
